// File: rtl/iiitb_cg_pkg.sv
// -----------------------------------------------------------------------------
// iiitb_cg_pkg
// Shared types and constants for the clock-gating controller slice.
//   cg_state_t   : controller state (ON / OFF / WAKE), 2-bit encoding
//   GE_MAX       : saturation value of the gate-event counter
//   *_DEF        : default parameter values used by the modules and interface
//   sat_inc8     : saturating 8-bit increment used by the event counter
// -----------------------------------------------------------------------------
package iiitb_cg_pkg;

    typedef enum logic [1:0] {
        ON   = 2'd0,
        OFF  = 2'd1,
        WAKE = 2'd2
    } cg_state_t;

    localparam logic [7:0] GE_MAX = 8'd255;

    localparam int DW_DEF         = 2;
    localparam int IDLE_LIMIT_DEF = 8;
    localparam int WAKE_DELAY_DEF = 2;
    localparam int CNT_W_DEF      = 4;

    // Increment that sticks at GE_MAX instead of wrapping to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v >= GE_MAX) begin
            r = GE_MAX;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iiitb_cg_ctrl_if.sv
// -----------------------------------------------------------------------------
// iiitb_cg_ctrl_if
// Bundle of the controller's data-side signals.
//   d_in        : data presented to the gated register bank (DW bits)
//   force_on    : forces activity every cycle
//   en          : registered ICG enable, 1 = clock running
//   gated       : registered, 1 only while the bank clock is stopped
//   idle_cnt    : idle/wake counter (debug, CNT_W bits)
//   gate_events : saturating count of ON->OFF transitions
// Modports: master = traffic source / observer, slave = controller.
// -----------------------------------------------------------------------------
interface iiitb_cg_ctrl_if
    import iiitb_cg_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic [DW-1:0]    d_in;
    logic             force_on;
    logic             en;
    logic             gated;
    logic [CNT_W-1:0] idle_cnt;
    logic [7:0]       gate_events;

    modport master (
        output d_in,
        output force_on,
        input  en,
        input  gated,
        input  idle_cnt,
        input  gate_events
    );

    modport slave (
        input  d_in,
        input  force_on,
        output en,
        output gated,
        output idle_cnt,
        output gate_events
    );

endinterface

// File: rtl/iiitb_cg_actdet.sv
// -----------------------------------------------------------------------------
// iiitb_cg_actdet
// Activity detector for a gated register bank: flags a cycle as active when
// the incoming data differs from the previous cycle's data, or when forced.
// The history register runs on the ungated clock so it keeps tracking d_in
// while the bank itself is stopped.
//   clk      : ungated clock
//   rst      : synchronous active-high reset (clears history to zero)
//   d_in     : monitored data (DW bits)
//   force_on : treat every cycle as active
//   act      : combinational activity flag, consumed by registered logic only
// -----------------------------------------------------------------------------
module iiitb_cg_actdet
    import iiitb_cg_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d_in,
    input  logic          force_on,
    output logic          act
);

    logic [DW-1:0] d_last_r;

    // Previous-cycle copy of the monitored data.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_last_r <= {DW{1'b0}};
        end else begin
            d_last_r <= d_in;
        end
    end

    assign act = (d_in != d_last_r) | force_on;

endmodule

// File: rtl/iiitb_cg_ctrl.sv
// -----------------------------------------------------------------------------
// iiitb_cg_ctrl
// Clock-gating controller driving the enable pin of the integrated clock-gate.
// Counts consecutive idle cycles in ON and drops the enable after IDLE_LIMIT
// of them; any activity while OFF re-enables the clock and holds it for
// WAKE_DELAY cycles (activity ignored) before idle counting resumes.
//   clk : ungated clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : slave side of iiitb_cg_ctrl_if (d_in, force_on in; en, gated,
//         idle_cnt, gate_events out, all outputs registered)
// Legal ranges: IDLE_LIMIT and WAKE_DELAY in 1..2^CNT_W-1.
// -----------------------------------------------------------------------------
module iiitb_cg_ctrl
    import iiitb_cg_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int IDLE_LIMIT = IDLE_LIMIT_DEF,
    parameter int WAKE_DELAY = WAKE_DELAY_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    iiitb_cg_ctrl_if.slave bus
);

    // Terminal counts: the transition fires on the cycle the counter already
    // holds LIMIT-1, so the window is exactly LIMIT cycles long.
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_LIMIT - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    cg_state_t        state_r;
    logic             en_r;
    logic             gated_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       ev_r;
    logic             act_s;

    iiitb_cg_actdet #(
        .DW (DW)
    ) u_actdet (
        .clk      (clk),
        .rst      (rst),
        .d_in     (bus.d_in),
        .force_on (bus.force_on),
        .act      (act_s)
    );

    // Gating FSM with its idle/wake counter and the gate-event counter.
    // The ">=" compares keep a corrupted counter from running past its
    // terminal value; in normal operation they behave as equality.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ON;
            en_r    <= 1'b1;
            gated_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
            ev_r    <= 8'd0;
        end else begin
            case (state_r)
                ON: begin
                    en_r    <= 1'b1;
                    gated_r <= 1'b0;
                    if (act_s) begin
                        // Activity wins over an expiring idle window.
                        cnt_r <= CNT_ZERO;
                    end else if (cnt_r >= IDLE_LAST) begin
                        state_r <= OFF;
                        en_r    <= 1'b0;
                        gated_r <= 1'b1;
                        cnt_r   <= CNT_ZERO;
                        ev_r    <= sat_inc8(ev_r);
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                OFF: begin
                    en_r    <= 1'b0;
                    gated_r <= 1'b1;
                    cnt_r   <= CNT_ZERO;
                    if (act_s) begin
                        state_r <= WAKE;
                        en_r    <= 1'b1;
                        gated_r <= 1'b0;
                    end else begin
                        state_r <= OFF;
                    end
                end
                WAKE: begin
                    // Clock held on unconditionally; activity is ignored here.
                    en_r    <= 1'b1;
                    gated_r <= 1'b0;
                    if (cnt_r >= WAKE_LAST) begin
                        state_r <= ON;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to the clock-running state.
                    state_r <= ON;
                    en_r    <= 1'b1;
                    gated_r <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.en          = en_r;
    assign bus.gated       = gated_r;
    assign bus.idle_cnt    = cnt_r;
    assign bus.gate_events = ev_r;

endmodule
